// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier core between two requesters.
// Latency: grant 1 cycle after request sample, rvalid >= 3 cycles; requests ignored while busy.
module mult_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [2*WIDTH-1:0]   result,
    output logic                 timeout_err,
    output logic                 busy,
    output logic [WIDTH-1:0]     mult_a,
    output logic [WIDTH-1:0]     mult_b,
    output logic                 mult_start,
    input  logic                 mult_done,
    input  logic [2*WIDTH-1:0]   mult_res
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               rvalid0_q, rvalid0_d;
    logic               rvalid1_q, rvalid1_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               terr_q, terr_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   mult_a_q, mult_a_d;
    logic [WIDTH-1:0]   mult_b_q, mult_b_d;
    logic               start_q, start_d;
    logic               win1;

    // On a tie, the requester that was not served last wins.
    assign win1 = req1 & (~req0 | ~last_q);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        start_d   = 1'b0;
        result_d  = result_q;
        terr_d    = terr_q;
        busy_d    = busy_q;
        mult_a_d  = mult_a_q;
        mult_b_d  = mult_b_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (req0 || req1) begin
                    owner_d  = win1;
                    mult_a_d = win1 ? a1 : a0;
                    mult_b_d = win1 ? b1 : b0;
                    gnt0_d   = ~win1;
                    gnt1_d   = win1;
                    start_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                if (mult_done) begin
                    result_d  = mult_res;
                    terr_d    = 1'b0;
                    rvalid0_d = ~owner_q;
                    rvalid1_d = owner_q;
                    state_d   = RESP;
                end else if (cnt_q == CNT_MAX) begin
                    result_d  = '0;
                    terr_d    = 1'b1;
                    rvalid0_d = ~owner_q;
                    rvalid1_d = owner_q;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                last_d  = owner_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            result_q  <= '0;
            terr_q    <= 1'b0;
            busy_q    <= 1'b0;
            mult_a_q  <= '0;
            mult_b_q  <= '0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            result_q  <= result_d;
            terr_q    <= terr_d;
            busy_q    <= busy_d;
            mult_a_q  <= mult_a_d;
            mult_b_q  <= mult_b_d;
            start_q   <= start_d;
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign rvalid0     = rvalid0_q;
    assign rvalid1     = rvalid1_q;
    assign result      = result_q;
    assign timeout_err = terr_q;
    assign busy        = busy_q;
    assign mult_a      = mult_a_q;
    assign mult_b      = mult_b_q;
    assign mult_start  = start_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: transaction-level arbitration model plus a simple core model.
module tb_mult_arbiter;
    localparam int W  = 8;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic           mult_done = 1'b0;
    logic [2*W-1:0] mult_res = '0;
    logic           gnt0, gnt1, rvalid0, rvalid1, timeout_err, busy, mult_start;
    logic [2*W-1:0] result;
    logic [W-1:0]   mult_a, mult_b;

    mult_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .result(result), .timeout_err(timeout_err), .busy(busy),
        .mult_a(mult_a), .mult_b(mult_b), .mult_start(mult_start),
        .mult_done(mult_done), .mult_res(mult_res)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    bit last_m   = 1'b1;

    // Observations from the most recent operation
    int             o_win, o_gnt_cnt, o_start_cnt, o_rv_tick, o_rv_owner;
    bit             o_rv_both, o_busy_gnt, o_busy_after;
    logic [W-1:0]   o_a, o_b;
    logic [2*W-1:0] o_res;
    logic           o_terr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(bit r0, bit r1, bit last);
        if (r0 && r1) return last ? 0 : 1;
        return r1 ? 1 : 0;
    endfunction

    function automatic logic [2*W-1:0] prod(logic [W-1:0] x, logic [W-1:0] y);
        return {{W{1'b0}}, x} * {{W{1'b0}}, y};
    endfunction

    // Runs one operation: k = BUSY edge on which done is sampled (0 = never).
    task automatic run_op(input int k, input bit stray, input bit late);
        o_win = -1; o_gnt_cnt = 0; o_start_cnt = 0; o_rv_tick = -1; o_rv_owner = -1;
        o_rv_both = 1'b0; o_res = 'x; o_terr = 1'bx;
        for (int n = 0; n < 20; n++) begin
            tick();
            o_gnt_cnt += int'(gnt0) + int'(gnt1);
            if (mult_start) break;
        end
        if (!mult_start) return;
        o_win = gnt1 ? 1 : (gnt0 ? 0 : -1);
        o_start_cnt = 1;
        o_a = mult_a; o_b = mult_b; o_busy_gnt = busy;
        mult_done = stray;
        mult_res  = 16'($urandom);
        for (int j = 1; j <= TO + 3; j++) begin
            tick();
            o_gnt_cnt   += int'(gnt0) + int'(gnt1);
            o_start_cnt += int'(mult_start);
            if (late && j == 2) begin
                req0 = 1'b0;
                req1 = 1'b1;
            end
            if (rvalid0 || rvalid1) begin
                o_rv_tick  = j;
                o_rv_owner = rvalid1 ? 1 : 0;
                o_rv_both  = rvalid0 && rvalid1;
                o_res      = result;
                o_terr     = timeout_err;
                break;
            end
            mult_done = (j == k);
            mult_res  = (j == k) ? prod(mult_a, mult_b) : 16'($urandom);
        end
        mult_done = 1'b0;
        tick();
        o_busy_after = busy;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        last_m = 1'b1;
    endtask

    task automatic test_reset();
        logic [4*W+7-1+1:0] outs;
        tick(); tick();
        outs = {gnt0, gnt1, rvalid0, rvalid1, mult_start, busy, timeout_err, result, mult_a, mult_b};
        chk_cnt++; if (outs !== '0) $display("FAIL reset_outputs got=%h exp=0", outs); else pass_cnt++;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        req0 = 1'b1; a0 = 8'd12; b0 = 8'd13;
        run_op(5, 1'b0, 1'b0);
        req0 = 1'b0;
        chk_cnt++; if (o_win !== 0) $display("FAIL single_winner got=%0d exp=0", o_win); else pass_cnt++;
        chk_cnt++; if (o_gnt_cnt !== 1) $display("FAIL single_gnt_count got=%0d exp=1", o_gnt_cnt); else pass_cnt++;
        chk_cnt++; if (o_start_cnt !== 1) $display("FAIL single_start_count got=%0d exp=1", o_start_cnt); else pass_cnt++;
        chk_cnt++; if ({o_a, o_b} !== {8'd12, 8'd13}) $display("FAIL single_operands got=%0d,%0d exp=12,13", o_a, o_b); else pass_cnt++;
        chk_cnt++; if (o_rv_tick !== 6) $display("FAIL single_rvalid_time got=%0d exp=6", o_rv_tick); else pass_cnt++;
        chk_cnt++; if (o_rv_owner !== 0 || o_rv_both) $display("FAIL single_rvalid_owner got=%0d both=%0d exp=0", o_rv_owner, o_rv_both); else pass_cnt++;
        chk_cnt++; if (o_res !== 16'd156) $display("FAIL single_result got=%0d exp=156", o_res); else pass_cnt++;
        chk_cnt++; if (o_terr !== 1'b0) $display("FAIL single_terr got=%0b exp=0", o_terr); else pass_cnt++;
        chk_cnt++; if ({o_busy_gnt, o_busy_after} !== 2'b10) $display("FAIL single_busy got=%b exp=10", {o_busy_gnt, o_busy_after}); else pass_cnt++;
        last_m = 1'b0;
    endtask

    task automatic test_tie();
        int exp_w;
        do_reset();
        req0 = 1'b1; req1 = 1'b1; a0 = 8'd3; b0 = 8'd4; a1 = 8'd5; b1 = 8'd6;
        for (int i = 0; i < 4; i++) begin
            exp_w = pick(1'b1, 1'b1, last_m);
            run_op(int'($urandom_range(1, 6)), 1'b0, 1'b0);
            chk_cnt++; if (o_win !== exp_w || o_gnt_cnt !== 1) $display("FAIL tie_grant%0d got=%0d cnt=%0d exp=%0d", i, o_win, o_gnt_cnt, exp_w); else pass_cnt++;
            chk_cnt++; if (o_rv_owner !== exp_w || o_res !== (exp_w == 1 ? 16'd30 : 16'd12)) $display("FAIL tie_result%0d got=%0d/%0d exp_owner=%0d", i, o_rv_owner, o_res, exp_w); else pass_cnt++;
            last_m = exp_w[0];
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_timeout();
        req1 = 1'b1; a1 = 8'd9; b1 = 8'd11;
        run_op(0, 1'b0, 1'b0);
        req1 = 1'b0;
        chk_cnt++; if (o_rv_tick !== TO + 1) $display("FAIL timeout_time got=%0d exp=%0d", o_rv_tick, TO + 1); else pass_cnt++;
        chk_cnt++; if (o_rv_owner !== 1 || o_res !== '0 || o_terr !== 1'b1) $display("FAIL timeout_resp got=%0d/%0d/%0b exp=1/0/1", o_rv_owner, o_res, o_terr); else pass_cnt++;
        last_m = 1'b1;
        req1 = 1'b1;
        run_op(3, 1'b0, 1'b0);
        req1 = 1'b0;
        chk_cnt++; if (o_terr !== 1'b0 || o_res !== 16'd99) $display("FAIL timeout_recover got=%0d/%0b exp=99/0", o_res, o_terr); else pass_cnt++;
    endtask

    task automatic test_done_on_edge();
        req0 = 1'b1; a0 = 8'd200; b0 = 8'd250;
        run_op(TO, 1'b0, 1'b0);
        req0 = 1'b0;
        chk_cnt++; if (o_rv_tick !== TO + 1) $display("FAIL edge_time got=%0d exp=%0d", o_rv_tick, TO + 1); else pass_cnt++;
        chk_cnt++; if (o_res !== 16'd50000 || o_terr !== 1'b0) $display("FAIL edge_resp got=%0d/%0b exp=50000/0", o_res, o_terr); else pass_cnt++;
        last_m = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        logic [4*W+7-1+1:0] outs;
        req0 = 1'b1; req1 = 1'b1;
        for (int n = 0; n < 20 && !mult_start; n++) tick();
        chk_cnt++; if (gnt1 !== 1'b1) $display("FAIL midreset_pre_winner got=%0b exp=1", gnt1); else pass_cnt++;
        tick(); tick(); tick();
        reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        tick();
        reset_n = 1'b1; last_m = 1'b1;
        outs = {gnt0, gnt1, rvalid0, rvalid1, mult_start, busy, timeout_err, result, mult_a, mult_b};
        chk_cnt++; if (outs !== '0) $display("FAIL midreset_outputs got=%h exp=0", outs); else pass_cnt++;
        for (int n = 0; n < 20; n++) begin
            tick();
            bad += int'(rvalid0) + int'(rvalid1) + int'(mult_start);
        end
        chk_cnt++; if (bad !== 0) $display("FAIL midreset_silent got=%0d exp=0", bad); else pass_cnt++;
        req0 = 1'b1; req1 = 1'b1;
        run_op(2, 1'b0, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        chk_cnt++; if (o_win !== 0) $display("FAIL midreset_tie got=%0d exp=0", o_win); else pass_cnt++;
        last_m = 1'b0;
    endtask

    task automatic test_stray_late();
        int bad = 0;
        mult_done = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            bad += int'(rvalid0) + int'(rvalid1) + int'(busy);
        end
        mult_done = 1'b0;
        chk_cnt++; if (bad !== 0) $display("FAIL stray_idle got=%0d exp=0", bad); else pass_cnt++;
        req0 = 1'b1; a0 = 8'd7; b0 = 8'd8; a1 = 8'd10; b1 = 8'd10;
        run_op(4, 1'b1, 1'b1);
        chk_cnt++; if (o_rv_tick !== 5 || o_rv_owner !== 0) $display("FAIL stray_start got=%0d/%0d exp=5/0", o_rv_tick, o_rv_owner); else pass_cnt++;
        chk_cnt++; if (o_gnt_cnt !== 1 || o_res !== 16'd56) $display("FAIL late_ignored got=%0d/%0d exp=1/56", o_gnt_cnt, o_res); else pass_cnt++;
        last_m = 1'b0;
        run_op(2, 1'b0, 1'b0);
        req1 = 1'b0;
        chk_cnt++; if (o_win !== 1 || o_res !== 16'd100) $display("FAIL late_served got=%0d/%0d exp=1/100", o_win, o_res); else pass_cnt++;
        last_m = 1'b1;
    endtask

    task automatic test_random();
        int exp_w, k;
        bit r0, r1;
        logic [2*W-1:0] exp_p;
        for (int i = 0; i < 12; i++) begin
            r0 = 1'($urandom); r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            req0 = r0; req1 = r1;
            a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
            exp_w = pick(r0, r1, last_m);
            exp_p = (exp_w == 1) ? prod(a1, b1) : prod(a0, b0);
            k = int'($urandom_range(1, 8));
            run_op(k, 1'($urandom), 1'b0);
            chk_cnt++; if (o_win !== exp_w || o_rv_owner !== exp_w || o_gnt_cnt !== 1) $display("FAIL rand_owner%0d got=%0d/%0d exp=%0d", i, o_win, o_rv_owner, exp_w); else pass_cnt++;
            chk_cnt++; if (o_res !== exp_p || o_terr !== 1'b0 || o_rv_tick !== k + 1) $display("FAIL rand_result%0d got=%0d t=%0d exp=%0d t=%0d", i, o_res, o_rv_tick, exp_p, k + 1); else pass_cnt++;
            last_m = exp_w[0];
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_timeout();
        test_done_on_edge();
        test_reset_mid();
        test_stray_late();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
